// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline register with valid/ready handshake and a two-entry skid buffer.
// All outputs, including ready_o, are driven straight from flops.
module if_id_skid_stage #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] instr_i,
  input  logic [WIDTH-1:0] pc_plus4_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] pc_plus4_o,
  output logic [1:0]       occupancy_o
);

  localparam logic [WIDTH-1:0] NOP = WIDTH'(NOP_INSTR);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t           state;
  logic [WIDTH-1:0] skid_instr, skid_pc;
  logic             in_fire, out_fire;

  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= EMPTY;
      instr_o     <= NOP;
      pc_plus4_o  <= '0;
      skid_instr  <= '0;
      skid_pc     <= '0;
      valid_o     <= 1'b0;
      ready_o     <= 1'b1;
      occupancy_o <= 2'd0;
    end else if (flush_i) begin
      // Skid contents are left alone; they become unreachable once state is EMPTY.
      state       <= EMPTY;
      instr_o     <= NOP;
      pc_plus4_o  <= '0;
      valid_o     <= 1'b0;
      ready_o     <= 1'b1;
      occupancy_o <= 2'd0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state       <= BUSY;
            instr_o     <= instr_i;
            pc_plus4_o  <= pc_plus4_i;
            valid_o     <= 1'b1;
            occupancy_o <= 2'd1;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            instr_o    <= instr_i;
            pc_plus4_o <= pc_plus4_i;
          end else if (in_fire) begin
            state       <= FULL;
            skid_instr  <= instr_i;
            skid_pc     <= pc_plus4_i;
            ready_o     <= 1'b0;
            occupancy_o <= 2'd2;
          end else if (out_fire) begin
            state       <= EMPTY;
            instr_o     <= NOP;
            pc_plus4_o  <= '0;
            valid_o     <= 1'b0;
            occupancy_o <= 2'd0;
          end
        end
        FULL: begin
          // ready_o is low here, so only the output side can move.
          if (out_fire) begin
            state       <= BUSY;
            instr_o     <= skid_instr;
            pc_plus4_o  <= skid_pc;
            ready_o     <= 1'b1;
            occupancy_o <= 2'd1;
          end
        end
        default: begin
          state       <= EMPTY;
          instr_o     <= NOP;
          pc_plus4_o  <= '0;
          valid_o     <= 1'b0;
          ready_o     <= 1'b1;
          occupancy_o <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage: a FIFO-queue model is checked every
// cycle, with literal expectations at key points of each scenario.
module tb_if_id_skid_stage;

  localparam int          WIDTH = 32;
  localparam logic [31:0] NOPI  = 32'h0000_0013;

  logic             clk_i = 1'b0, reset_i = 1'b1, flush_i = 1'b0;
  logic             valid_i = 1'b0, ready_i = 1'b0;
  logic [WIDTH-1:0] instr_i = '0, pc_plus4_i = '0;
  logic             ready_o, valid_o;
  logic [WIDTH-1:0] instr_o, pc_plus4_o;
  logic [1:0]       occupancy_o;

  int vectors = 0, miscompares = 0;

  if_id_skid_stage #(.WIDTH(WIDTH), .NOP_INSTR(NOPI)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o), .instr_i(instr_i), .pc_plus4_i(pc_plus4_i),
    .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o), .pc_plus4_o(pc_plus4_o),
    .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the stage is a FIFO of at most two {instr, pc} entries; head is on the outputs.
  logic [63:0] q[$];

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i || flush_i) q.delete();
    else begin
      bit inf, outf;
      inf  = valid_i && (q.size() < 2);
      outf = (q.size() > 0) && ready_i;
      if (outf) void'(q.pop_front());
      if (inf) q.push_back({instr_i, pc_plus4_i});
    end
  end

  always @(negedge clk_i) begin
    chk("m_valid", valid_o, q.size() > 0);
    chk("m_ready", ready_o, q.size() < 2);
    chk("m_occ", occupancy_o, q.size());
    chk("m_instr", instr_o, (q.size() > 0) ? q[0][63:32] : NOPI);
    chk("m_pc", pc_plus4_o, (q.size() > 0) ? q[0][31:0] : 32'h0);
  end

  task automatic cyc();
    @(posedge clk_i); #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    valid_i = v; instr_i = ins; pc_plus4_i = pc;
  endtask

  initial begin
    logic [31:0] cnt;
    bit          fire;

    // Reset then idle
    cyc(); cyc();
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_instr", instr_o, NOPI);
    chk("rst_pc", pc_plus4_o, 0);
    chk("rst_occ", occupancy_o, 0);
    reset_i = 1'b0;
    cyc();

    // Streaming at full rate
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h11 + i, 32'h4 * (i + 1));
      cyc();
      chk("stream_instr", instr_o, 32'h11 + i);
      chk("stream_pc", pc_plus4_o, 32'h4 * (i + 1));
      chk("stream_occ", occupancy_o, 1);
    end
    drive(1'b0, 0, 0); cyc();
    chk("stream_drain", valid_o, 0);

    // Back-pressure into the skid register
    ready_i = 1'b0;
    drive(1'b1, 32'hA1, 32'h100); cyc();
    drive(1'b1, 32'hA2, 32'h104); cyc();
    chk("bp_ready", ready_o, 0);
    chk("bp_occ", occupancy_o, 2);
    chk("bp_hold", instr_o, 32'hA1);
    drive(1'b1, 32'hA3, 32'h108); cyc();
    chk("bp_hold2", instr_o, 32'hA1);
    ready_i = 1'b1; cyc();
    chk("bp_out2", instr_o, 32'hA2);
    chk("bp_ready_back", ready_o, 1);
    cyc();
    chk("bp_out3", instr_o, 32'hA3);
    chk("bp_out3_pc", pc_plus4_o, 32'h108);
    drive(1'b0, 0, 0); cyc();
    chk("bp_empty", valid_o, 0);

    // Flush while FULL, with a third entry offered
    ready_i = 1'b0;
    drive(1'b1, 32'hB1, 32'h200); cyc();
    drive(1'b1, 32'hB2, 32'h204); cyc();
    drive(1'b1, 32'hB3, 32'h208); flush_i = 1'b1; cyc();
    flush_i = 1'b0;
    chk("fl_valid", valid_o, 0);
    chk("fl_instr", instr_o, NOPI);
    chk("fl_ready", ready_o, 1);
    chk("fl_occ", occupancy_o, 0);
    drive(1'b0, 0, 0); ready_i = 1'b1; cyc(); cyc();
    chk("fl_no_b3", valid_o, 0);

    // Toggling ready_i with fetch always offering
    cnt = 32'h300;
    for (int i = 0; i < 20; i++) begin
      ready_i = i[0];
      drive(1'b1, cnt, cnt + 32'h4);
      fire = ready_o;
      cyc();
      if (fire) cnt++;
      chk("tog_occ_nz", occupancy_o != 0, 1);
    end
    drive(1'b0, 0, 0); ready_i = 1'b1; cyc(); cyc(); cyc();
    chk("tog_drained", valid_o, 0);

    // Async reset in the middle of a stall
    ready_i = 1'b0;
    drive(1'b1, 32'hD1, 32'h400); cyc();
    drive(1'b1, 32'hD2, 32'h404); cyc();
    chk("ar_full", occupancy_o, 2);
    #2 reset_i = 1'b1;
    #1;
    chk("ar_valid", valid_o, 0);
    chk("ar_ready", ready_o, 1);
    chk("ar_instr", instr_o, NOPI);
    chk("ar_occ", occupancy_o, 0);
    #3 reset_i = 1'b0;
    drive(1'b1, 32'hC1, 32'h500); ready_i = 1'b1;
    cyc();
    chk("ar_c1", instr_o, 32'hC1);
    chk("ar_c1_valid", valid_o, 1);
    drive(1'b0, 0, 0); cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_id_skid_stage.md
# if_id_skid_stage

Parametrised fetch-to-decode pipeline stage with a valid/ready handshake, a two-entry skid buffer and a synchronous flush. It sits between the fetch stage and the decode stage of the pipelined core and replaces the plain enable-gated IF/ID register. Stalls come from decode back-pressure (ready_i) rather than a global enable. Branch redirects use flush_i, which injects a NOP bubble. Neither ready_o nor any other output depends combinationally on ready_i.

## Interface
- WIDTH, 32: width of instruction and PC+4 payloads.
- NOP_INSTR, 32'h0000_0000: instruction word presented on instr_o whenever the stage holds no valid entry; truncated/zero-extended to WIDTH.
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous flush; discards all held and incoming entries.
- valid_i  in  1  fetch presents a valid instruction.
- ready_o  out  1  stage can accept an entry this cycle (registered).
- instr_i  in  WIDTH  fetched instruction.
- pc_plus4_i  in  WIDTH  PC+4 of fetched instruction.
- valid_o  out  1  instr_o/pc_plus4_o hold a valid entry.
- ready_i  in  1  decode accepts the entry this cycle.
- instr_o  out  WIDTH  instruction to decode.
- pc_plus4_o  out  WIDTH  PC+4 to decode.
- occupancy_o  out  2  entries held: 0, 1 or 2.

## Operation
- Input fire: valid_i & ready_o. Output fire: valid_o & ready_i.
- Storage: main register, which drives the outputs, plus a skid register. Both hold instr and pc_plus4.
- States:
  - EMPTY: occupancy 0, valid_o=0, ready_o=1.
  - BUSY: occupancy 1, valid_o=1, ready_o=1.
  - FULL: occupancy 2, valid_o=1, ready_o=0.
- Transitions when flush_i=0:
  - EMPTY, in fire: load main, go to BUSY.
  - EMPTY, no in fire: stay.
  - BUSY, in fire & out fire: load main with new input, stay BUSY.
  - BUSY, in fire & no out fire: load skid, go to FULL. Main is unchanged.
  - BUSY, out fire & no in fire: main <= {NOP_INSTR, 0}, go to EMPTY.
  - BUSY, neither fire: hold.
  - FULL, out fire: main <= skid, go to BUSY. No input can fire because ready_o=0.
  - FULL, no out fire: hold everything.
- Flush, highest priority over all fires:
  - Next state EMPTY; main <= {NOP_INSTR, 0}; skid contents don't-care.
  - An input presented in the same cycle is dropped, even if ready_o=1.
  - An output fire in the same cycle still counts as consumed by decode.
- Reset: identical to flush, applied asynchronously.
- Entries leave in arrival order. No entry is duplicated or lost, except by flush.
- Payload is passed bit-exact with no arithmetic. Skid register contents are never visible on the outputs until moved into main.
- While valid_o=1 and ready_i=0, instr_o/pc_plus4_o/valid_o stay stable.

## Timing
- Reset values:
  - valid_o=0, ready_o=1, instr_o=NOP_INSTR, pc_plus4_o=0, occupancy_o=0.
  - State EMPTY.
- Latency: an entry accepted at edge N is on instr_o/valid_o after edge N when the stage was EMPTY or draining.
- Throughput: one entry per cycle sustained while ready_i=1.
- ready_o, valid_o, occupancy_o and all data outputs come directly from flops, so there is no combinational path from any input to any output.
- ready_o deasserts in the cycle after the skid register fills. It reasserts in the cycle after the first output fire in FULL.
- Flush takes effect at the next edge. In the following cycle, valid_o=0 and ready_o=1.
- Reset asserted mid-transfer clears immediately, without waiting for a clock edge. The first input can be accepted at the first edge after deassertion.

## Test plan
- Reset then idle: assert reset_i; check valid_o=0, ready_o=1, instr_o=NOP_INSTR, pc_plus4_o=0, occupancy_o=0.
- Streaming: ready_i=1; send instr 0x11..0x18 with pc_plus4 0x4..0x20 on consecutive cycles. Each appears one cycle later with no gaps, and occupancy_o stays 1.
- Back-pressure: with the stage BUSY holding 0xA1, drop ready_i and send 0xA2 then 0xA3.
  - 0xA2 enters skid; ready_o falls; 0xA3 is held by fetch; occupancy_o=2; outputs stay 0xA1.
  - Raise ready_i: decode receives 0xA1, 0xA2, 0xA3 in order with no loss.
- Flush in FULL: with 0xB1 in main, 0xB2 in skid and valid_i=1 carrying 0xB3, assert flush_i one cycle.
  - Next cycle: valid_o=0, instr_o=NOP_INSTR, ready_o=1, occupancy_o=0.
  - 0xB3 is never output.
- Simultaneous in/out fire in BUSY while ready_i toggles every cycle: the decode-side order matches the fetch-side order exactly, and occupancy_o stays in 1..2.
- Async reset mid-stall: in FULL, pulse reset_i between clock edges. Outputs clear before the next edge; the next accepted 0xC1 appears after one edge.
